// File: rtl/data_memory_bytelane.sv
// rtl/data_memory_bytelane.sv - byte-lane data memory for the RV32 load/store path
//
// Purpose: byte-addressable word memory that decodes RV32I load/store funct3,
// writes individual byte lanes, returns sign/zero-extended load data through a
// registered one-cycle response, and flags misaligned/illegal and out-of-range
// accesses. With CLEAR_ON_RESET=1 an init sequencer zeroes every word after
// reset release before the first request is accepted.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          reset, asynchronous, active-low
//   i_req_valid    request present
//   o_req_ready    request accepted this cycle when high together with i_req_valid
//   i_we           1 = store, 0 = load
//   i_funct3       RV32I load/store funct3
//   i_addr         byte address
//   i_wdata        store data, LSB-aligned
//   o_rsp_valid    one-cycle response pulse, one edge after acceptance
//   o_rdata        extended load data; 0 for stores, faults and idle cycles
//   o_misaligned   misaligned access or illegal funct3
//   o_out_of_range byte address beyond the array
module data_memory_bytelane #(
  parameter int DEPTH_WORDS    = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_out_of_range
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  localparam state_e ST_RESET = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q;
  logic [31:0]       rdata_q;
  logic              mis_q, oor_q;

  // Memory contents are deliberately outside the reset domain.
  logic [3:0][7:0]   mem_q [DEPTH_WORDS];

  logic              accept;
  logic [AW-1:0]     word_idx;
  logic [1:0]        lane;
  logic              illegal_f3;
  logic              misaligned;
  logic              out_of_range;
  logic              fault;
  logic [3:0]        byte_en;
  logic [3:0][7:0]   wr_bytes;
  logic [3:0][7:0]   rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_data;

  assign accept   = i_req_valid && ready_q;
  assign word_idx = i_addr[AW+1:2];
  assign lane     = i_addr[1:0];

  // Request decode: faults, byte enables and load extension.
  always_comb begin
    illegal_f3   = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    byte_en      = 4'b0000;
    wr_bytes     = i_wdata;
    ld_data      = 32'h0;
    rd_word      = mem_q[word_idx];
    rd_byte      = rd_word[lane];
    rd_half      = lane[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};

    if (i_we) begin
      illegal_f3 = !(i_funct3 == 3'b000 || i_funct3 == 3'b001 || i_funct3 == 3'b010);
    end else begin
      illegal_f3 = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
    end

    misaligned = illegal_f3
              || (i_funct3[1:0] == 2'b01 && lane[0])
              || (i_funct3 == 3'b010 && lane != 2'b00);

    // Any set bit above the word index puts the address past the array.
    out_of_range = (i_addr[31:AW+2] != '0);

    fault = misaligned || out_of_range;

    // Store data is replicated across lanes so each enabled lane just copies its own byte.
    case (i_funct3[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << lane;
        wr_bytes = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wr_bytes = {2{i_wdata[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_bytes = i_wdata;
      end
    endcase

    case (i_funct3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, rd_byte};
      3'b101:  ld_data = {16'h0, rd_half};
      default: ld_data = 32'h0;
    endcase
  end

  // Control FSM: INIT walks the array once, IDLE accepts requests forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        // Ready is registered, so it rises on the first edge spent in IDLE.
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      mis_q       <= 1'b0;
      oor_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= accept;
      rdata_q     <= (accept && !i_we && !fault) ? ld_data : 32'h0;
      mis_q       <= accept && misaligned;
      oor_q       <= accept && out_of_range;
    end
  end

  // Read-before-write is not an issue: a load in the cycle after a store sees
  // the array already updated on the store's edge.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= 32'h0;
    end else if (accept && i_we && !fault) begin
      for (int l = 0; l < 4; l++) begin
        if (byte_en[l]) begin
          mem_q[word_idx][l] <= wr_bytes[l];
        end
      end
    end
  end

  assign o_req_ready    = ready_q;
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rdata        = rdata_q;
  assign o_misaligned   = mis_q;
  assign o_out_of_range = oor_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// tb/tb_data_memory_bytelane.sv - scoreboard bench for data_memory_bytelane
module tb_data_memory_bytelane;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_rsp_valid;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic        o_out_of_range;

  int n_checks = 0;
  int n_fail   = 0;
  int idle_dirty = 0;

  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];

  data_memory_bytelane #(.DEPTH_WORDS(16), .CLEAR_ON_RESET(1)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_we           (i_we),
    .i_funct3       (i_funct3),
    .i_addr         (i_addr),
    .i_wdata        (i_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .o_rdata        (o_rdata),
    .o_misaligned   (o_misaligned),
    .o_out_of_range (o_out_of_range)
  );

  always #5 i_clk = ~i_clk;

  // Response monitor: collect every pulse, and note any nonzero data outside a pulse.
  always @(negedge i_clk) begin
    if (o_rsp_valid) begin
      obs_q.push_back({o_rdata, o_misaligned, o_out_of_range});
    end else if (o_rdata !== 32'h0 || o_misaligned !== 1'b0 || o_out_of_range !== 1'b0) begin
      idle_dirty++;
    end
  end

  // Drive one request for one cycle (called at a negedge) and record its expected response.
  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] erd,
                     input logic emis, input logic eoor);
    i_req_valid = 1'b1;
    i_we        = we;
    i_funct3    = f3;
    i_addr      = addr;
    i_wdata     = wdata;
    exp_q.push_back({erd, emis, eoor});
    @(negedge i_clk);
  endtask

  task automatic go_idle();
    i_req_valid = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_reset();
    logic [33:0] e, o;
    #1;
    i_rst = 1'b0;
    i_req_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h3C; i_wdata = 32'h0;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if ({o_req_ready, o_rsp_valid, o_rdata, o_misaligned, o_out_of_range} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got ready=%b rsp=%b rdata=%h mis=%b oor=%b want all 0",
               o_req_ready, o_rsp_valid, o_rdata, o_misaligned, o_out_of_range);
    end
    i_rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge i_clk); #1;
      n_checks++;
      if (o_req_ready !== (k == 17)) begin
        n_fail++;
        $display("FAIL init_ready edge=%0d got %b want %b", k, o_req_ready, (k == 17));
      end
    end
    exp_q.push_back({32'h0, 1'b0, 1'b0});
    @(negedge i_clk);
    @(negedge i_clk);
    go_idle();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_rsp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_lw3c got rdata=%h mis=%b oor=%b want rdata=%h mis=%b oor=%b",
                 o[33:2], o[1], o[0], e[33:2], e[1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_byte_loads();
    logic [33:0] e, o;
    req(1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 0, 0);
    req(0, 3'b000, 32'h10, 32'h0, 32'h00000001, 0, 0);
    req(0, 3'b000, 32'h11, 32'h0, 32'h0000007F, 0, 0);
    req(0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFFF, 0, 0);
    req(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, 0);
    req(0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0, 0);
    go_idle();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL byte_rsp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL byte_load got rdata=%h mis=%b oor=%b want rdata=%h mis=%b oor=%b",
                 o[33:2], o[1], o[0], e[33:2], e[1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_half_lanes();
    logic [33:0] e, o;
    req(1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0, 0);
    req(1, 3'b001, 32'h22, 32'h1234BEEF, 32'h0, 0, 0);
    req(1, 3'b000, 32'h20, 32'h556677AA, 32'h0, 0, 0);
    req(0, 3'b010, 32'h20, 32'h0, 32'hBEEF33AA, 0, 0);
    req(0, 3'b001, 32'h22, 32'h0, 32'hFFFFBEEF, 0, 0);
    req(0, 3'b101, 32'h22, 32'h0, 32'h0000BEEF, 0, 0);
    req(0, 3'b101, 32'h20, 32'h0, 32'h000033AA, 0, 0);
    go_idle();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL half_rsp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL half_lane got rdata=%h mis=%b oor=%b want rdata=%h mis=%b oor=%b",
                 o[33:2], o[1], o[0], e[33:2], e[1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_misaligned();
    logic [33:0] e, o;
    req(0, 3'b010, 32'h22, 32'h0,        32'h0, 1, 0);
    req(1, 3'b001, 32'h21, 32'h00005555, 32'h0, 1, 0);
    req(0, 3'b011, 32'h00, 32'h0,        32'h0, 1, 0);
    req(1, 3'b100, 32'h20, 32'h000000CC, 32'h0, 1, 0);
    req(0, 3'b010, 32'h20, 32'h0, 32'hBEEF33AA, 0, 0);
    go_idle();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL misalign_rsp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL misalign got rdata=%h mis=%b oor=%b want rdata=%h mis=%b oor=%b",
                 o[33:2], o[1], o[0], e[33:2], e[1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_out_of_range();
    logic [33:0] e, o;
    req(1, 3'b010, 32'h40,       32'hDEADBEEF, 32'h0, 0, 1);
    req(0, 3'b001, 32'h41,       32'h0,        32'h0, 1, 1);
    req(1, 3'b000, 32'h80000000, 32'h000000EE, 32'h0, 0, 1);
    req(0, 3'b010, 32'h00,       32'h0,        32'h0, 0, 0);
    go_idle();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL oor_rsp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL out_of_range got rdata=%h mis=%b oor=%b want rdata=%h mis=%b oor=%b",
                 o[33:2], o[1], o[0], e[33:2], e[1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [33:0] e, o;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      req(1, 3'b010, 32'h30 + 32'(4 * i), d, 32'h0, 0, 0);
      req(0, 3'b010, 32'h30 + 32'(4 * i), 32'h0, d, 0, 0);
    end
    go_idle();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_rsp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b got rdata=%h mis=%b oor=%b want rdata=%h mis=%b oor=%b",
                 o[33:2], o[1], o[0], e[33:2], e[1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if (idle_dirty != 0) begin
      n_fail++;
      $display("FAIL idle_outputs got %0d nonzero idle cycles want 0", idle_dirty);
    end
  endtask

  task automatic test_reset_midstream();
    logic [33:0] e, o;
    req(1, 3'b010, 32'h34, 32'h0BADF00D, 32'h0, 0, 0);
    req(0, 3'b010, 32'h34, 32'h0,        32'h0BADF00D, 0, 0);
    i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h38; i_wdata = 32'hCAFEF00D;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midstream_rsp_before got %b want 1", o_rsp_valid);
    end
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midstream_rsp_drop got rsp=%b ready=%b want 0 0", o_rsp_valid, o_req_ready);
    end
    i_req_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge i_clk); #1;
      n_checks++;
      if (o_req_ready !== (k == 17)) begin
        n_fail++;
        $display("FAIL reinit_ready edge=%0d got %b want %b", k, o_req_ready, (k == 17));
      end
    end
    @(negedge i_clk);
    req(0, 3'b010, 32'h34, 32'h0, 32'h0, 0, 0);
    req(0, 3'b010, 32'h38, 32'h0, 32'h0, 0, 0);
    go_idle();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midstream_rsp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midstream got rdata=%h mis=%b oor=%b want rdata=%h mis=%b oor=%b",
                 o[33:2], o[1], o[0], e[33:2], e[1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_byte_loads();
    test_half_lanes();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no end of test want completion");
    $fatal(1, "timeout");
  end

endmodule
